// File: rtl/note_lane_shifter.sv
// Multi-lane note-scroll shift register with hit-window judging and miss counting.
// Lanes scroll toward bit 0 every rate+1 enabled cycles. A strike consumes the
// lowest note in the judge window. Notes that leave bit 0 unjudged count as misses.
module note_lane_shifter #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DEPTH   = 100,
  parameter int unsigned HIT_WIN = 4,
  parameter int unsigned RATE_W  = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [LANES*DEPTH-1:0] load_val,
  input  logic [LANES-1:0]       in,
  input  logic                   shift_en,
  input  logic [RATE_W-1:0]      rate,
  input  logic                   hit_req,
  input  logic [LANE_W-1:0]      hit_lane,
  output logic [LANES*DEPTH-1:0] out,
  output logic                   step,
  output logic                   hit_ok,
  output logic                   hit_miss,
  output logic [LANES-1:0]       drop,
  output logic [CNT_W-1:0]       miss_count
);

  localparam int unsigned IdxW   = (HIT_WIN > 1) ? $clog2(HIT_WIN) : 1;
  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  logic [LANES*DEPTH-1:0] lanes_q, lanes_d;
  logic [RATE_W-1:0]      rc_q, rc_d;
  logic                   step_q, step_d;
  logic                   hit_ok_q, hit_ok_d;
  logic                   hit_miss_q, hit_miss_d;
  logic [LANES-1:0]       drop_q, drop_d;
  logic [CNT_W-1:0]       miss_count_q, miss_count_d;

  logic                   hit_valid;
  logic                   hit_found;
  logic [IdxW-1:0]        hit_idx;
  logic [DEPTH-1:0]       sel_lane;
  logic [DEPTH-1:0]       clr_mask;
  logic [DEPTH-1:0]       lane_tmp;
  logic [LANES*DEPTH-1:0] cleared;
  logic                   scroll;
  logic [31:0]            add;
  logic [31:0]            tot;

  // Select the struck lane and find the lowest occupied bit in its judge window.
  always_comb begin
    hit_valid = 1'b0;
    sel_lane  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (hit_req && (hit_lane == LANE_W'(k))) begin
        hit_valid = 1'b1;
        sel_lane  = lanes_q[k*DEPTH +: DEPTH];
      end
    end
    hit_found = 1'b0;
    hit_idx   = '0;
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = int'(HIT_WIN) - 1; i >= 0; i--) begin
      if (sel_lane[i]) begin
        hit_found = 1'b1;
        hit_idx   = IdxW'(i);
      end
    end
  end

  // Next state: load beats everything; otherwise hit-clear, then scroll, then count.
  always_comb begin
    lanes_d      = lanes_q;
    rc_d         = rc_q;
    step_d       = 1'b0;
    hit_ok_d     = 1'b0;
    hit_miss_d   = 1'b0;
    drop_d       = '0;
    miss_count_d = miss_count_q;
    cleared      = lanes_q;
    scroll       = 1'b0;
    lane_tmp     = '0;
    add          = '0;
    tot          = '0;
    clr_mask     = DEPTH'(1) << hit_idx;

    if (load) begin
      lanes_d = load_val;
      rc_d    = '0;
    end else begin
      // Counter wraps naturally, so a rate lowered below rc scrolls after wrap.
      if (shift_en) begin
        if (rc_q == rate) begin
          scroll = 1'b1;
          rc_d   = '0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end

      hit_ok_d   = hit_valid & hit_found;
      hit_miss_d = hit_valid & ~hit_found;

      for (int k = 0; k < int'(LANES); k++) begin
        if (hit_ok_d && (hit_lane == LANE_W'(k))) begin
          cleared[k*DEPTH +: DEPTH] = lanes_q[k*DEPTH +: DEPTH] & ~clr_mask;
        end
      end

      if (scroll) begin
        step_d = 1'b1;
        for (int k = 0; k < int'(LANES); k++) begin
          lane_tmp                  = cleared[k*DEPTH +: DEPTH] >> 1;
          lane_tmp[DEPTH-1]         = in[k];
          lanes_d[k*DEPTH +: DEPTH] = lane_tmp;
          // Judged from the cleared lane so a just-consumed bit 0 is not a drop.
          drop_d[k]                 = cleared[k*DEPTH];
        end
      end else begin
        lanes_d = cleared;
      end

      add = 32'(hit_miss_d);
      for (int k = 0; k < int'(LANES); k++) begin
        add = add + 32'(drop_d[k]);
      end
      tot          = 32'(miss_count_q) + add;
      miss_count_d = (tot > CntMax) ? CNT_W'(CntMax) : CNT_W'(tot);
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lanes_q      <= '0;
      rc_q         <= '0;
      step_q       <= 1'b0;
      hit_ok_q     <= 1'b0;
      hit_miss_q   <= 1'b0;
      drop_q       <= '0;
      miss_count_q <= '0;
    end else begin
      lanes_q      <= lanes_d;
      rc_q         <= rc_d;
      step_q       <= step_d;
      hit_ok_q     <= hit_ok_d;
      hit_miss_q   <= hit_miss_d;
      drop_q       <= drop_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign out        = lanes_q;
  assign step       = step_q;
  assign hit_ok     = hit_ok_q;
  assign hit_miss   = hit_miss_q;
  assign drop       = drop_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_note_lane_shifter.sv
// Bench for note_lane_shifter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a lane-array reference model.
module tb_note_lane_shifter;

  localparam int unsigned LANES   = 3;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned HIT_WIN = 4;
  localparam int unsigned RATE_W  = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned W       = LANES * DEPTH;
  localparam int          CNT_MAX = 15;
  localparam int          NV      = 21;

  logic              clock = 1'b0;
  logic              reset, load, shift_en, hit_req;
  logic [W-1:0]      load_val;
  logic [LANES-1:0]  in;
  logic [RATE_W-1:0] rate;
  logic [LANE_W-1:0] hit_lane;
  logic [W-1:0]      out;
  logic              step, hit_ok, hit_miss;
  logic [LANES-1:0]  drop;
  logic [CNT_W-1:0]  miss_count;

  always #5 clock = ~clock;

  note_lane_shifter #(
    .LANES(LANES), .DEPTH(DEPTH), .HIT_WIN(HIT_WIN), .RATE_W(RATE_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val), .in(in),
    .shift_en(shift_en), .rate(rate), .hit_req(hit_req), .hit_lane(hit_lane),
    .out(out), .step(step), .hit_ok(hit_ok), .hit_miss(hit_miss), .drop(drop),
    .miss_count(miss_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each lane is a plain bit array, index 0 is the judge end.
  bit               m_lane [LANES][DEPTH];
  int               m_rc, m_mc;
  bit               m_step, m_ok, m_miss;
  bit [LANES-1:0]   m_drop;

  function automatic void model_edge();
    int first, n, hl;
    bit do_scroll;
    m_step = 1'b0; m_ok = 1'b0; m_miss = 1'b0; m_drop = '0;
    if (reset) begin
      foreach (m_lane[k, j]) m_lane[k][j] = 1'b0;
      m_rc = 0; m_mc = 0;
      return;
    end
    if (load) begin
      foreach (m_lane[k, j]) m_lane[k][j] = load_val[k*DEPTH+j];
      m_rc = 0;
      return;
    end
    do_scroll = shift_en && (m_rc == int'(rate));
    if (shift_en) m_rc = do_scroll ? 0 : (m_rc + 1) % (1 << RATE_W);
    hl = int'(hit_lane);
    if (hit_req && hl < int'(LANES)) begin
      first = -1;
      for (int i = 0; i < int'(HIT_WIN); i++) if (first < 0 && m_lane[hl][i]) first = i;
      if (first >= 0) begin
        m_lane[hl][first] = 1'b0;
        m_ok = 1'b1;
      end else begin
        m_miss = 1'b1;
      end
    end
    if (do_scroll) begin
      m_step = 1'b1;
      for (int k = 0; k < int'(LANES); k++) begin
        m_drop[k] = m_lane[k][0];
        for (int j = 0; j < int'(DEPTH) - 1; j++) m_lane[k][j] = m_lane[k][j+1];
        m_lane[k][DEPTH-1] = in[k];
      end
    end
    n = m_mc + int'(m_miss) + $countones(m_drop);
    m_mc = (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic logic [W-1:0] m_out();
    logic [W-1:0] v;
    v = '0;
    foreach (m_lane[k, j]) v[k*DEPTH+j] = m_lane[k][j];
    return v;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void chk_all(string tag, logic [W-1:0] e_out, logic e_step,
                                  logic e_ok, logic e_miss, logic [LANES-1:0] e_drop,
                                  logic [CNT_W-1:0] e_mc);
    chk({tag, " out"}, 32'(out), 32'(e_out));
    chk({tag, " step"}, 32'(step), 32'(e_step));
    chk({tag, " hit_ok"}, 32'(hit_ok), 32'(e_ok));
    chk({tag, " hit_miss"}, 32'(hit_miss), 32'(e_miss));
    chk({tag, " drop"}, 32'(drop), 32'(e_drop));
    chk({tag, " miss_count"}, 32'(miss_count), 32'(e_mc));
  endfunction

  task automatic drive(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic [LANES-1:0] i, input logic s,
                       input logic [RATE_W-1:0] rt, input logic h,
                       input logic [LANE_W-1:0] hl);
    reset = r; load = l; load_val = lv; in = i; shift_en = s; rate = rt;
    hit_req = h; hit_lane = hl;
  endtask

  // Advance the model alongside the DUT edge, then sample 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic rst, ld; logic [W-1:0] lv; logic [LANES-1:0] in; logic se;
    logic [RATE_W-1:0] rate; logic hr; logic [LANE_W-1:0] hl;
    logic [W-1:0] e_out; logic e_step, e_ok, e_miss; logic [LANES-1:0] e_drop;
    logic [CNT_W-1:0] e_mc;
  } vec_t;

  vec_t vecs [NV];
  logic [RATE_W-1:0] rate_r;

  initial begin
    // rst ld load_val in se rate hr hl | out step ok miss drop mc
    // Reset beats load/hit; then rate=3 scrolls on the 4th enabled cycle.
    vecs[0]  = '{1'b1, 1'b1, 24'hFFFFFF, 3'b111, 1'b1, 3'd3, 1'b1, 2'd0,
                 24'h000000, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0};
    for (int r = 1; r <= 3; r++)
      vecs[r] = '{1'b0, 1'b0, 24'h0, 3'b101, 1'b1, 3'd3, 1'b0, 2'd0,
                  24'h000000, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 24'h0, 3'b101, 1'b1, 3'd3, 1'b0, 2'd0,
                 24'h800080, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0};
    // lane0 = 1<<2 at rate 0: drops on the third scroll.
    vecs[5]  = '{1'b0, 1'b1, 24'h000004, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000004, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0};
    vecs[6]  = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000002, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0};
    vecs[7]  = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000001, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0};
    vecs[8]  = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000000, 1'b1, 1'b0, 1'b0, 3'b001, 4'd1};
    vecs[9]  = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000000, 1'b1, 1'b0, 1'b0, 3'b000, 4'd1};
    // lane1 = 1<<3, no scrolling: hit consumes, second hit misses.
    vecs[10] = '{1'b0, 1'b1, 24'h000800, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0,
                 24'h000800, 1'b0, 1'b0, 1'b0, 3'b000, 4'd1};
    vecs[11] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd1,
                 24'h000000, 1'b0, 1'b1, 1'b0, 3'b000, 4'd1};
    vecs[12] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd1,
                 24'h000000, 1'b0, 1'b0, 1'b1, 3'b000, 4'd2};
    // lane0 = 0b11: hit during scroll clears bit 0 first, so no drop.
    vecs[13] = '{1'b0, 1'b1, 24'h000003, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0,
                 24'h000003, 1'b0, 1'b0, 1'b0, 3'b000, 4'd2};
    vecs[14] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b1, 2'd0,
                 24'h000001, 1'b1, 1'b1, 1'b0, 3'b000, 4'd2};
    vecs[15] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0,
                 24'h000000, 1'b1, 1'b0, 1'b0, 3'b001, 4'd3};
    // Out-of-range lane is ignored.
    vecs[16] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd3,
                 24'h000000, 1'b0, 1'b0, 1'b0, 3'b000, 4'd3};
    // lane2 = 0xAC: lowest window bit first, bits above the window untouched.
    vecs[17] = '{1'b0, 1'b1, 24'hAC0000, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0,
                 24'hAC0000, 1'b0, 1'b0, 1'b0, 3'b000, 4'd3};
    vecs[18] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd2,
                 24'hA80000, 1'b0, 1'b1, 1'b0, 3'b000, 4'd3};
    vecs[19] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd2,
                 24'hA00000, 1'b0, 1'b1, 1'b0, 3'b000, 4'd3};
    vecs[20] = '{1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd2,
                 24'hA00000, 1'b0, 1'b0, 1'b1, 3'b000, 4'd4};

    for (int r = 0; r < NV; r++) begin
      drive(vecs[r].rst, vecs[r].ld, vecs[r].lv, vecs[r].in, vecs[r].se, vecs[r].rate,
            vecs[r].hr, vecs[r].hl);
      tick();
      chk_all($sformatf("vec%0d", r), vecs[r].e_out, vecs[r].e_step, vecs[r].e_ok,
              vecs[r].e_miss, vecs[r].e_drop, vecs[r].e_mc);
    end

    // Saturation (count 4 -> 15) with a load in the middle that resets rc only.
    drive(1'b0, 1'b1, 24'hFFFFFF, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0); tick();
    chk("sat load mc", 32'(miss_count), 32'd4);
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0); tick();
    chk("sat s1 drop", 32'(drop), 32'h7);
    chk("sat s1 mc", 32'(miss_count), 32'd7);
    tick();
    chk("sat s2 mc", 32'(miss_count), 32'd10);
    drive(1'b0, 1'b1, 24'hFFFFFF, 3'b000, 1'b1, 3'd2, 1'b0, 2'd0); tick();
    chk("midload mc", 32'(miss_count), 32'd10);
    chk("midload step", 32'(step), 32'd0);
    chk("midload drop", 32'(drop), 32'd0);
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd2, 1'b0, 2'd0);
    tick(); chk("rc0 c1 step", 32'(step), 32'd0);
    tick(); chk("rc0 c2 step", 32'(step), 32'd0);
    tick(); chk("rc0 c3 step", 32'(step), 32'd1);
    chk("rc0 c3 mc", 32'(miss_count), 32'd13);
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd0, 1'b0, 2'd0);
    tick(); chk("sat c4 mc", 32'(miss_count), 32'd15);
    tick(); chk("sat c5 mc", 32'(miss_count), 32'd15);
    chk("sat c5 drop", 32'(drop), 32'h7);
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b1, 2'd3); tick();
    chk("badlane ok", 32'(hit_ok), 32'd0);
    chk("badlane miss", 32'(hit_miss), 32'd0);

    // Rate lowered below rc: counter runs on through wrap before the next scroll.
    drive(1'b1, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0); tick();
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd5, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("wrap pre%0d step", i), 32'(step), 32'd0);
    end
    drive(1'b0, 1'b0, 24'h0, 3'b000, 1'b1, 3'd1, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      tick(); chk($sformatf("wrap c%0d step", i), 32'(step), (i == 6) ? 32'd1 : 32'd0);
    end

    // Randomized traffic against the model.
    drive(1'b1, 1'b0, 24'h0, 3'b000, 1'b0, 3'd0, 1'b0, 2'd0); tick();
    chk_all("rnd reset", m_out(), m_step, m_ok, m_miss, m_drop, CNT_W'(m_mc));
    rate_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0)
        rate_r = ($urandom_range(0, 4) == 0) ? RATE_W'($urandom) : RATE_W'($urandom_range(0, 2));
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0, W'($urandom),
            LANES'($urandom), $urandom_range(0, 3) != 0, rate_r,
            $urandom_range(0, 2) == 0, LANE_W'($urandom));
      tick();
      chk_all($sformatf("rnd%0d", c), m_out(), m_step, m_ok, m_miss, m_drop, CNT_W'(m_mc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
